// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl: Z80 interrupt controller with pending/missed flags, enable mask, /INT hold limit and IM2 vector
// Ports:
//   clk_z80   clock; rst_n synchronous active-low reset
//   src_stb   one-cycle event strobes, bit 0 (timer) has highest priority
//   m1_n      Z80 /M1; iorq_n Z80 /IORQ (both synchronous to clk_z80)
//   cfg_we    config write strobe; cfg_wdata [2:0] enable, [3] clear pending, [4] clear missed
//   int_n     registered /INT; int_vec registered IM2 vector; vec_oe bus drive enable
//   pend      pending flags; missed sticky missed flags; enable current mask
module z80_int_ctrl #(
    parameter logic [7:0] VEC_BASE  = 8'hF8,
    parameter int         HOLD_CLKS = 32
) (
    input  logic       clk_z80,
    input  logic       rst_n,
    input  logic [2:0] src_stb,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       cfg_we,
    input  logic [7:0] cfg_wdata,
    output logic       int_n,
    output logic [7:0] int_vec,
    output logic       vec_oe,
    output logic [2:0] pend,
    output logic [2:0] missed,
    output logic [2:0] enable
);
    typedef enum logic [1:0] {IDLE, ASSERT, ACK, GAP} state_t;
    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt, vec_nxt, sel_vec;
    logic       int_n_nxt, req, ack, unused_cfg;
    logic [1:0] sel;
    logic [2:0] act, sel_mask, fsm_clr, fsm_miss, pend_clr, miss_clr;
    assign unused_cfg = ^cfg_wdata[7:5];
    assign act      = pend & enable;
    assign req      = |act;
    assign sel      = act[0] ? 2'd0 : act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd0;
    assign sel_mask = 3'b001 << sel;
    assign sel_vec  = VEC_BASE | {5'b0, sel, 1'b0};
    assign ack      = !m1_n && !iorq_n;
    assign vec_oe   = ack && (state == ASSERT || state == ACK);
    // A strobe landing on a flag being cleared wins: pend stays set and no miss is recorded.
    assign pend_clr = fsm_clr | {3{cfg_we & cfg_wdata[3]}};
    assign miss_clr = {3{cfg_we & cfg_wdata[4]}};
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        vec_nxt   = int_vec;
        int_n_nxt = int_n;
        fsm_clr   = 3'b000;
        fsm_miss  = 3'b000;
        case (state)
            IDLE: if (req) begin
                state_nxt = ASSERT;
                hold_nxt  = 8'd1;
                int_n_nxt = 1'b0;
                vec_nxt   = sel_vec;
            end
            ASSERT: if (ack) begin
                state_nxt = ACK;
                int_n_nxt = 1'b1;
                fsm_clr   = sel_mask;
            end else if (!req) begin
                state_nxt = IDLE;
                int_n_nxt = 1'b1;
            end else if (hold_cnt == 8'(HOLD_CLKS)) begin
                state_nxt = IDLE;
                int_n_nxt = 1'b1;
                fsm_clr   = sel_mask;
                fsm_miss  = sel_mask & ~src_stb;
            end else begin
                hold_nxt  = hold_cnt + 8'd1;
                vec_nxt   = sel_vec;
            end
            ACK: if (iorq_n) state_nxt = GAP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_z80) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            int_n    <= 1'b1;
            int_vec  <= VEC_BASE;
            pend     <= 3'b000;
            missed   <= 3'b000;
            enable   <= 3'b000;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            int_n    <= int_n_nxt;
            int_vec  <= vec_nxt;
            pend     <= (pend & ~pend_clr) | src_stb;
            missed   <= (missed & ~miss_clr) | (src_stb & pend & ~pend_clr) | fsm_miss;
            if (cfg_we) enable <= cfg_wdata[2:0];
        end
    end
endmodule

// File: tb/tb_z80_int_ctrl.sv
// tb_z80_int_ctrl: directed and random checks of z80_int_ctrl against a behavioural model
module tb_z80_int_ctrl;
    localparam int         HOLD = 32;
    localparam logic [7:0] VB   = 8'hF8;
    localparam int P_IDLE = 0, P_LOW = 1, P_ACK = 2, P_GAP = 3;
    logic       clk_z80 = 1'b0, rst_n = 1'b0, m1_n = 1'b1, iorq_n = 1'b1, cfg_we = 1'b0;
    logic [2:0] src_stb = 3'b000;
    logic [7:0] cfg_wdata = 8'h00;
    logic       int_n, vec_oe;
    logic [7:0] int_vec;
    logic [2:0] pend, missed, enable;
    int n_chk = 0, n_err = 0;
    int ph = P_IDLE, held = 0, low_run = 0;
    logic [2:0] m_pend = 0, m_missed = 0, m_en = 0;
    logic       m_intn = 1'b1;
    logic [7:0] m_vec = VB;
    bit         m_valid = 1'b0;

    z80_int_ctrl dut (
        .clk_z80(clk_z80), .rst_n(rst_n), .src_stb(src_stb), .m1_n(m1_n), .iorq_n(iorq_n),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .int_n(int_n), .int_vec(int_vec),
        .vec_oe(vec_oe), .pend(pend), .missed(missed), .enable(enable)
    );

    always #5 clk_z80 = ~clk_z80;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] s, input logic m1, input logic io,
                         input logic we, input logic [7:0] wd, input logic rn);
        logic [2:0] act, clr, tmiss, mclr;
        int sel;
        if (!rn) begin
            ph = P_IDLE; held = 0; m_pend = 0; m_missed = 0; m_en = 0;
            m_intn = 1'b1; m_vec = VB; m_valid = 1'b1;
        end else begin
            act = m_pend & m_en;
            sel = act[0] ? 0 : act[1] ? 1 : act[2] ? 2 : 0;
            clr = 0; tmiss = 0; mclr = 0;
            if (ph == P_IDLE) begin
                if (act != 0) begin
                    ph = P_LOW; held = 1; m_intn = 1'b0; m_vec = VB + 8'(2 * sel);
                end
            end else if (ph == P_LOW) begin
                if (!m1 && !io) begin
                    ph = P_ACK; m_intn = 1'b1; clr[sel] = 1'b1;
                end else if (act == 0) begin
                    ph = P_IDLE; m_intn = 1'b1;
                end else if (held == HOLD) begin
                    ph = P_IDLE; m_intn = 1'b1; clr[sel] = 1'b1; tmiss[sel] = !s[sel];
                end else begin
                    held++; m_vec = VB + 8'(2 * sel);
                end
            end else if (ph == P_ACK) begin
                if (io) ph = P_GAP;
            end else ph = P_IDLE;
            if (we) begin
                m_en = wd[2:0];
                if (wd[3]) clr = 3'b111;
                if (wd[4]) mclr = 3'b111;
            end
            m_missed = (m_missed & ~mclr) | (s & m_pend & ~clr) | tmiss;
            m_pend   = (m_pend & ~clr) | s;
        end
    endtask

    task automatic step(input logic [2:0] s, input logic m1, input logic io,
                        input logic we, input logic [7:0] wd, input logic rn);
        src_stb = s; m1_n = m1; iorq_n = io; cfg_we = we; cfg_wdata = wd; rst_n = rn;
        #1;
        if (m_valid) chk("vec_oe", vec_oe, !m1 && !io && (ph == P_LOW || ph == P_ACK));
        @(posedge clk_z80);
        model(s, m1, io, we, wd, rn);
        #1;
        chk("int_n", int_n, m_intn);
        chk("int_vec", int_vec, m_vec);
        chk("pend", pend, m_pend);
        chk("missed", missed, m_missed);
        chk("enable", enable, m_en);
        low_run = int_n ? 0 : low_run + 1;
        chk("low_run", low_run <= HOLD, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask
    task automatic cfg(input logic [7:0] wd);
        step(3'b000, 1'b1, 1'b1, 1'b1, wd, 1'b1);
    endtask
    task automatic stb(input logic [2:0] s);
        step(s, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask
    task automatic ack(input logic [2:0] s);
        step(s, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        int cnt;
        step(3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step(3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_int_n", int_n, 1);
        chk("rst_vec", int_vec, 8'hF8);
        chk("rst_pend", pend, 0);
        chk("rst_missed", missed, 0);
        chk("rst_enable", enable, 0);
        // basic assert and ack of source 0
        cfg(8'h01);
        stb(3'b001);
        chk("t1_pend", pend, 3'b001);
        chk("t1_int_hi", int_n, 1);
        idle(1);
        chk("t1_int_lo", int_n, 0);
        chk("t1_vec", int_vec, 8'hF8);
        src_stb = 0; m1_n = 0; iorq_n = 0; #1;
        chk("t1_oe", vec_oe, 1);
        ack(3'b000);
        chk("t1_ack_int", int_n, 1);
        chk("t1_ack_pend", pend, 0);
        ack(3'b000);
        step(3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        idle(2);
        // priority between sources 1 and 2, then re-assertion after gap
        cfg(8'h07);
        stb(3'b110);
        idle(1);
        chk("t2_vec1", int_vec, 8'hFA);
        chk("t2_lo1", int_n, 0);
        ack(3'b000);
        chk("t2_pend", pend, 3'b100);
        chk("t2_hi_a", int_n, 1);
        idle(1);
        chk("t2_hi_b", int_n, 1);
        idle(1);
        chk("t2_hi_c", int_n, 1);
        idle(1);
        chk("t2_lo2", int_n, 0);
        chk("t2_vec2", int_vec, 8'hFC);
        ack(3'b000);
        idle(3);
        // timeout without ack
        cfg(8'h01);
        stb(3'b001);
        cnt = 0;
        idle(1);
        while (int_n == 1'b0 && cnt < 100) begin
            cnt++;
            idle(1);
        end
        chk("t3_len", cnt, HOLD);
        chk("t3_pend0", pend[0], 0);
        chk("t3_missed0", missed[0], 1);
        idle(3);
        chk("t3_int_hi", int_n, 1);
        // double strobe while masked, then combined clear and enable
        cfg(8'h18);
        stb(3'b001);
        idle(1);
        stb(3'b001);
        chk("t4_pend", pend, 3'b001);
        chk("t4_missed", missed, 3'b001);
        chk("t4_int", int_n, 1);
        cfg(8'h19);
        chk("t4c_pend", pend, 0);
        chk("t4c_missed", missed, 0);
        chk("t4c_enable", enable, 3'b001);
        chk("t4c_int", int_n, 1);
        idle(1);
        chk("t4d_int", int_n, 1);
        // strobe coinciding with ack of the same source
        stb(3'b001);
        idle(1);
        chk("t5_lo", int_n, 0);
        ack(3'b001);
        chk("t5_pend0", pend[0], 1);
        chk("t5_missed0", missed[0], 0);
        step(3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        idle(1);
        chk("t5_idle_hi", int_n, 1);
        idle(1);
        chk("t5_reassert", int_n, 0);
        ack(3'b000);
        idle(3);
        // reset during assertion
        stb(3'b001);
        idle(1);
        chk("t6_lo", int_n, 0);
        step(3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("t6_int", int_n, 1);
        chk("t6_pend", pend, 0);
        chk("t6_enable", enable, 0);
        stb(3'b001);
        idle(3);
        chk("t6_no_int", int_n, 1);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 6 == 0) ? 3'($urandom) : 3'b000,
                 ($urandom % 3 == 0) ? 1'b0 : 1'b1,
                 ($urandom % 3 == 0) ? 1'b0 : 1'b1,
                 ($urandom % 25 == 0) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom % 500 == 0) ? 1'b0 : 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
